// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
// Shared definitions for the PS/2 key event FIFO:
//   - bit positions of the fields inside the 11-bit hps_io ps2_key word
//   - key_entry_t, the 10-bit entry stored in the FIFO {pressed, extended, scancode}
package ps2_key_pkg;

    localparam int KEY_TOGGLE_BIT   = 10;
    localparam int KEY_PRESSED_BIT  = 9;
    localparam int KEY_EXTENDED_BIT = 8;
    localparam int KEY_CODE_MSB     = 7;
    localparam int KEY_CODE_LSB     = 0;
    localparam int ENTRY_W          = 10;

    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] scancode;
    } key_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is driven
// straight from storage, so dout is valid whenever empty is low.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push, din    write request and data; refused when full unless a pop
//                happens on the same edge
//   pop          removes the head; ignored while empty
//   dout         head entry (don't-care while empty)
//   count        entries held, 0..DEPTH
//   full, empty  status flags
module sync_fifo_fwft #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot being written, so a full FIFO
    // can still accept a push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
// Buffers hps_io PS/2 key events for a CPU. A new event is recognised when
// the toggle bit of ps2_key changes; {pressed, extended, scancode} is then
// pushed into a first-word-fall-through FIFO, visible one clock later.
// Ports:
//   clk_24        system clock
//   reset         synchronous active-high reset
//   ps2_key       [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   rd            pop strobe, one pulse per entry consumed
//   rd_data       head entry {pressed, extended, scancode}
//   empty, count  FIFO status
//   overflow      sticky: an event was dropped because the FIFO was full
//   clr_overflow  clears overflow (a simultaneous new overflow wins)
// Build option:
//   PS2_KEY_FIFO_TYPEMATIC_FILTER_EN  drops typematic repeats of the last
//   make code until the matching break is seen.
module ps2_key_fifo
    import ps2_key_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk_24,
    input  logic                    reset,
    input  logic [10:0]             ps2_key,
    input  logic                    rd,
    output logic [9:0]              rd_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    input  logic                    clr_overflow
);

    key_entry_t key_in;
    logic       prev_toggle;
    logic       key_event;
    logic       push_req;
    logic       full;

    assign key_in    = key_entry_t'(ps2_key[KEY_PRESSED_BIT:KEY_CODE_LSB]);
    assign key_event = ps2_key[KEY_TOGGLE_BIT] != prev_toggle;

    // Loading the live toggle during reset prevents a phantom event on release.
    always_ff @(posedge clk_24) begin
        prev_toggle <= ps2_key[KEY_TOGGLE_BIT];
    end

`ifdef PS2_KEY_FIFO_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic       last_valid;
    logic       code_match;
    logic       is_repeat;

    assign code_match = last_valid && (last_make == {key_in.extended, key_in.scancode});
    assign is_repeat  = key_in.pressed && code_match;
    assign push_req   = key_event && !is_repeat;

    always_ff @(posedge clk_24) begin
        if (reset) begin
            last_make  <= '0;
            last_valid <= 1'b0;
        end else if (key_event) begin
            if (key_in.pressed) begin
                if (!is_repeat) begin
                    last_make  <= {key_in.extended, key_in.scancode};
                    last_valid <= 1'b1;
                end
            end else if (code_match) begin
                last_valid <= 1'b0;
            end
        end
    end
`else
    assign push_req = key_event;
`endif

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_24),
        .reset (reset),
        .push  (push_req),
        .din   (key_in),
        .pop   (rd),
        .dout  (rd_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A full FIFO is never empty, so a rd on the same edge always makes room.
    always_ff @(posedge clk_24) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req && full && !rd) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
module tb_ps2_key_fifo;

    localparam int DEPTH = 16;

    logic        clk_24 = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        rd;
    logic [9:0]  rd_data;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        clr_overflow;

    int tests = 0;
    int fails = 0;

    bit       tog = 1'b0;
    bit [9:0] mq[$];
    bit       m_ovf;
    bit       m_prev;
    bit       m_lv;
    bit [8:0] m_lm;

    ps2_key_fifo #(.DEPTH(DEPTH)) dut (
        .clk_24       (clk_24),
        .reset        (reset),
        .ps2_key      (ps2_key),
        .rd           (rd),
        .rd_data      (rd_data),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk_24 = ~clk_24;

    // One clock: apply inputs, advance the reference model, sample 1 time unit after the edge.
    task automatic cycle(input bit [10:0] k, input bit r, input bit c, input bit rst);
        bit ev, pass, do_pop;
        ps2_key = k; rd = r; clr_overflow = c; reset = rst;
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_lv  = 0;
        end else begin
            ev     = (k[10] != m_prev);
            pass   = ev;
`ifdef PS2_KEY_FIFO_TYPEMATIC_FILTER_EN
            if (ev) begin
                if (k[9]) begin
                    if (m_lv && m_lm == k[8:0]) pass = 0;
                    else begin m_lm = k[8:0]; m_lv = 1; end
                end else if (m_lv && m_lm == k[8:0]) m_lv = 0;
            end
`endif
            do_pop = r && mq.size() > 0;
            if (c) m_ovf = 0;
            if (do_pop) void'(mq.pop_front());
            if (pass) begin
                if (mq.size() < DEPTH) mq.push_back(k[9:0]);
                else m_ovf = 1;
            end
        end
        m_prev = k[10];
        @(posedge clk_24);
        #1;
    endtask

    function automatic bit [10:0] ev_word(input bit [9:0] d);
        tog = ~tog;
        return {tog, d};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle({tog, 10'h000}, 0, 0, 0);
    endtask

    task automatic test_reset;
        cycle({tog, 10'h000}, 0, 0, 1);
        cycle({tog, 10'h000}, 0, 0, 1);
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
        cycle({tog, 10'h000}, 0, 0, 0);
    endtask

    task automatic test_single_event;
        cycle(ev_word(10'h21C), 0, 0, 0);
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL single_empty got %b want 0", empty); end
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
        tests++; if (rd_data !== 10'h21C) begin fails++; $display("FAIL single_data got %h want 21c", rd_data); end
        cycle({tog, 10'h21C}, 1, 0, 0);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty got %b want 1", empty); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 17; i++) cycle(ev_word({2'b10, 8'(i + 1)}), 0, 0, 0);
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_count got %0d want 16", count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf got %b want 1", overflow); end
        tests++; if (rd_data !== 10'h201) begin fails++; $display("FAIL fill_head got %h want 201", rd_data); end
        cycle({tog, 10'h000}, 0, 1, 0);
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_clr got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop;
        cycle(ev_word(10'h3AA), 1, 0, 0);
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL fullpp_count got %0d want 16", count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpp_ovf got %b want 0", overflow); end
        tests++; if (rd_data !== 10'h202) begin fails++; $display("FAIL fullpp_head got %h want 202", rd_data); end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (rd_data !== mq[0]) begin fails++; $display("FAIL fullpp_drain[%0d] got %h want %h", i, rd_data, mq[0]); end
            if (i == 15) begin
                tests++; if (rd_data !== 10'h3AA) begin fails++; $display("FAIL fullpp_tail got %h want 3aa", rd_data); end
            end
            cycle({tog, 10'h000}, 1, 0, 0);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fullpp_drained got %b want 1", empty); end
    endtask

    task automatic test_reset_midstream;
        for (int i = 0; i < 5; i++) cycle(ev_word({2'b10, 8'(8'h40 + i)}), 0, 0, 0);
        if (tog == 1'b0) begin tog = 1'b1; cycle({tog, 10'h0FF}, 1, 0, 1); end
        else cycle({tog, 10'h0FF}, 0, 0, 1);
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL midrst_count got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL midrst_empty got %b want 1", empty); end
        idle(3);
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL midrst_nopush got %0d want 0", count); end
    endtask

    task automatic test_filter;
        bit [9:0] exp[$];
        cycle({tog, 10'h000}, 0, 0, 1);
        cycle(ev_word(10'h21C), 0, 0, 0);
        cycle(ev_word(10'h21C), 0, 0, 0);
        cycle(ev_word(10'h21C), 0, 0, 0);
        cycle(ev_word(10'h01C), 0, 0, 0);
        cycle(ev_word(10'h21C), 0, 0, 0);
`ifdef PS2_KEY_FIFO_TYPEMATIC_FILTER_EN
        exp = '{10'h21C, 10'h01C, 10'h21C};
`else
        exp = '{10'h21C, 10'h21C, 10'h21C, 10'h01C, 10'h21C};
`endif
        tests++; if (count !== 5'(exp.size())) begin fails++; $display("FAIL filter_count got %0d want %0d", count, exp.size()); end
        foreach (exp[i]) begin
            tests++;
            if (rd_data !== exp[i]) begin fails++; $display("FAIL filter_entry[%0d] got %h want %h", i, rd_data, exp[i]); end
            cycle({tog, 10'h000}, 1, 0, 0);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL filter_empty got %b want 1", empty); end
    endtask

    task automatic test_rd_empty;
        for (int i = 0; i < 4; i++) cycle({tog, 10'h000}, 1, 0, 0);
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL rdempty_count got %0d want 0", count); end
        cycle(ev_word(10'h155), 0, 0, 0);
        tests++; if (rd_data !== 10'h155) begin fails++; $display("FAIL rdempty_data got %h want 155", rd_data); end
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL rdempty_count1 got %0d want 1", count); end
        cycle(ev_word(10'h0AB), 1, 0, 0);
        tests++; if (rd_data !== 10'h0AB) begin fails++; $display("FAIL rdempty_next got %h want 0ab", rd_data); end
        cycle({tog, 10'h000}, 1, 0, 0);
    endtask

    task automatic test_random;
        bit [10:0] k;
        bit        r, c, rst;
        int        rd_pct;
        for (int i = 0; i < 3000; i++) begin
            rd_pct = (i < 1500) ? 25 : 65;
            k = {tog, ps2_key[9:0]};
            if ($urandom_range(99) < 50)
                k = ev_word({1'($urandom_range(1)), 1'($urandom_range(1)),
                             ($urandom_range(3) == 0) ? 8'($urandom) : 8'h1C});
            r   = ($urandom_range(99) < rd_pct);
            c   = ($urandom_range(19) == 0);
            rst = ($urandom_range(399) == 0);
            cycle(k, r, c, rst);
            tests++;
            if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) || overflow !== m_ovf) begin
                fails++;
                $display("FAIL rand_status[%0d] got cnt=%0d e=%b o=%b want cnt=%0d e=%b o=%b",
                         i, count, empty, overflow, mq.size(), mq.size() == 0, m_ovf);
            end
            if (mq.size() > 0) begin
                tests++;
                if (rd_data !== mq[0]) begin fails++; $display("FAIL rand_data[%0d] got %h want %h", i, rd_data, mq[0]); end
            end
        end
    endtask

    initial begin
        ps2_key = '0; rd = 0; clr_overflow = 0; reset = 1;
        m_prev = 0;
        test_reset;
        test_single_event;
        test_fill;
        test_full_push_pop;
        test_reset_midstream;
        test_filter;
        test_rd_empty;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
